// File: rtl/mem_shift_ctrl.sv
// mem_shift_ctrl
//   Controls the shift data memory of the comparator datapath. In IDLE it
//   accepts samples with a valid/ready handshake, drives the memory's shift
//   enable and tracks how many entries are valid. On start it sweeps the
//   valid entries through mem_sel_o (0 = newest), keeps a running maximum
//   and delivers max, index and count through a result handshake.
//
// Build option:
//   MEM_SHIFT_CTRL_SIGNED_EN  defined   -> entries compared as two's complement
//                             undefined -> entries compared as unsigned
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   in_valid_i / in_ready_o   sample handshake; mem_enable_o = in_valid_i & in_ready_o
//   flush_i                   drop all stored entries (IDLE only)
//   start_i                   request a compare sweep (IDLE only)
//   busy_o                    high while sweeping or holding a result
//   mem_sel_o / mem_rdata_i   memory read select and combinational read data
//   fill_o                    number of valid entries, 0..DEPTH
//   res_valid_o / res_ready_i result handshake
//   res_max_o, res_idx_o, res_count_o  largest entry, its index, entries compared
//
// state     | meaning
// ST_IDLE   | accepting samples, waiting for start/flush
// ST_SWEEP  | reading entries 0..fill-1, one per cycle
// ST_RESULT | result presented until res_ready_i

module mem_shift_ctrl #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             mem_enable_o,
  input  logic             flush_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic [IDXW-1:0]  mem_sel_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic [IDXW:0]    fill_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_max_o,
  output logic [IDXW-1:0]  res_idx_o,
  output logic [IDXW:0]    res_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  localparam logic [IDXW:0]   FILL_FULL = (IDXW+1)'(DEPTH);
  localparam logic [IDXW:0]   FILL_ONE  = (IDXW+1)'(1);
  localparam logic [IDXW-1:0] SEL_ONE   = IDXW'(1);

  state_e           state_q, state_d;
  logic [IDXW:0]    fill_q,  fill_d;
  logic [IDXW-1:0]  sel_q,   sel_d;
  logic [WIDTH-1:0] max_q,   max_d;
  logic [IDXW-1:0]  idx_q,   idx_d;
  logic [IDXW:0]    cnt_q,   cnt_d;

  logic shift;
  logic greater;
  logic last_entry;

  // in_ready is forced low during reset so the memory never shifts while
  // the controller is held.
  assign in_ready_o   = (state_q == ST_IDLE) && !flush_i && !reset_i;
  assign shift        = in_valid_i && in_ready_o;
  assign mem_enable_o = shift;

`ifdef MEM_SHIFT_CTRL_SIGNED_EN
  assign greater = $signed(mem_rdata_i) > $signed(max_q);
`else
  assign greater = mem_rdata_i > max_q;
`endif

  // cnt_q holds the fill captured at start, so the sweep length is fixed
  // even though fill_q is free to be flushed later.
  assign last_entry = ({1'b0, sel_q} == (cnt_q - FILL_ONE));

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    sel_d   = sel_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          fill_d = '0;
        end else begin
          if (shift && (fill_q != FILL_FULL)) begin
            fill_d = fill_q + FILL_ONE;
          end
          // The sweep sees the fill including a shift accepted this cycle.
          if (start_i) begin
            cnt_d = fill_d;
            sel_d = '0;
            max_d = '0;
            idx_d = '0;
            state_d = (fill_d == '0) ? ST_RESULT : ST_SWEEP;
          end
        end
      end

      ST_SWEEP: begin
        // Entry 0 seeds the running max; later entries need strictly greater.
        if ((sel_q == '0) || greater) begin
          max_d = mem_rdata_i;
          idx_d = sel_q;
        end
        if (last_entry) begin
          sel_d   = '0;
          state_d = ST_RESULT;
        end else begin
          sel_d = sel_q + SEL_ONE;
        end
      end

      ST_RESULT: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      sel_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      sel_q   <= sel_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign res_valid_o = (state_q == ST_RESULT);
  assign mem_sel_o   = sel_q;
  assign fill_o      = fill_q;
  assign res_max_o   = max_q;
  assign res_idx_o   = idx_q;
  assign res_count_o = cnt_q;

endmodule

// File: tb/tb_mem_shift_ctrl.sv
module tb_mem_shift_ctrl;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int IDXW  = 3;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             mem_enable;
  logic             flush;
  logic             start;
  logic             busy;
  logic [IDXW-1:0]  mem_sel;
  logic [WIDTH-1:0] mem_rdata;
  logic [IDXW:0]    fill;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_max;
  logic [IDXW-1:0]  res_idx;
  logic [IDXW:0]    res_count;

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] mem [DEPTH];

  int n_chk;
  int n_err;

  // Reference contents: index 0 = newest, never more than DEPTH entries.
  logic [WIDTH-1:0] ref_q [$];

  mem_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mem_enable_o(mem_enable),
    .flush_i     (flush),
    .start_i     (start),
    .busy_o      (busy),
    .mem_sel_o   (mem_sel),
    .mem_rdata_i (mem_rdata),
    .fill_o      (fill),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_max_o   (res_max),
    .res_idx_o   (res_idx),
    .res_count_o (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift data memory seen by the controller.
  always @(posedge clk) begin
    if (mem_enable) begin
      for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= din;
    end
  end
  assign mem_rdata = mem[mem_sel];

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MEM_SHIFT_CTRL_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  task automatic model_result(output logic [WIDTH-1:0] emax, output int eidx);
    emax = '0;
    eidx = 0;
    for (int i = 0; i < ref_q.size(); i++) begin
      if (i == 0 || is_greater(ref_q[i], emax)) begin
        emax = ref_q[i];
        eidx = i;
      end
    end
  endtask

  task automatic model_push(input logic [WIDTH-1:0] v);
    ref_q.push_front(v);
    if (ref_q.size() > DEPTH) void'(ref_q.pop_back());
  endtask

  // All tasks start and end just after a falling edge.
  task automatic push(input logic [WIDTH-1:0] v);
    in_valid = 1'b1;
    din = v;
    #1;
    chk("push_in_ready", WIDTH'(in_ready), 1);
    chk("push_mem_enable", WIDTH'(mem_enable), 1);
    @(posedge clk);
    model_push(v);
    @(negedge clk);
    in_valid = 1'b0;
    chk("push_fill", WIDTH'(fill), WIDTH'(ref_q.size()));
  endtask

  task automatic flush_all();
    flush = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    din = 64'hDEAD;
    #1;
    chk("flush_mem_enable", WIDTH'(mem_enable), 0);
    chk("flush_in_ready", WIDTH'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    ref_q.delete();
    chk("flush_fill", WIDTH'(fill), 0);
    chk("flush_busy", WIDTH'(busy), 0);
    chk("flush_no_result", WIDTH'(res_valid), 0);
  endtask

  task automatic sweep(input int hold, input bit with_push, input logic [WIDTH-1:0] pv);
    logic [WIDTH-1:0] emax;
    int eidx;
    int f;
    start = 1'b1;
    if (with_push) begin
      in_valid = 1'b1;
      din = pv;
      #1;
      chk("start_push_enable", WIDTH'(mem_enable), 1);
    end
    @(posedge clk);
    if (with_push) model_push(pv);
    f = ref_q.size();
    model_result(emax, eidx);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < f; k++) begin
      chk("sweep_busy", WIDTH'(busy), 1);
      chk("sweep_sel", WIDTH'(mem_sel), WIDTH'(k));
      chk("sweep_early_valid", WIDTH'(res_valid), 0);
      chk("sweep_in_ready", WIDTH'(in_ready), 0);
      @(negedge clk);
    end
    chk("res_valid", WIDTH'(res_valid), 1);
    chk("res_busy", WIDTH'(busy), 1);
    chk("res_max", res_max, emax);
    chk("res_idx", WIDTH'(res_idx), WIDTH'(eidx));
    chk("res_count", WIDTH'(res_count), WIDTH'(f));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      din = {$urandom, $urandom};
      #1;
      chk("hold_mem_enable", WIDTH'(mem_enable), 0);
      @(negedge clk);
      chk("hold_valid", WIDTH'(res_valid), 1);
      chk("hold_max", res_max, emax);
      chk("hold_idx", WIDTH'(res_idx), WIDTH'(eidx));
      chk("hold_count", WIDTH'(res_count), WIDTH'(f));
      chk("hold_fill", WIDTH'(fill), WIDTH'(ref_q.size()));
    end
    in_valid = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("ack_busy", WIDTH'(busy), 0);
    chk("ack_valid", WIDTH'(res_valid), 0);
    chk("ack_in_ready", WIDTH'(in_ready), 1);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] v;
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    in_valid = 1'b1;
    flush = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    din = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    @(negedge clk);
    chk("rst_fill", WIDTH'(fill), 0);
    chk("rst_busy", WIDTH'(busy), 0);
    chk("rst_sel", WIDTH'(mem_sel), 0);
    chk("rst_valid", WIDTH'(res_valid), 0);
    chk("rst_max", res_max, 0);
    chk("rst_count", WIDTH'(res_count), 0);
    chk("rst_in_ready", WIDTH'(in_ready), 0);
    chk("rst_mem_enable", WIDTH'(mem_enable), 0);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    // Basic sweep: 5, 9, 3 with 3 newest.
    push(64'd5); push(64'd9); push(64'd3);
    sweep(0, 1'b0, '0);

    // Overflow: 1..10, fill saturates at DEPTH.
    flush_all();
    for (int i = 1; i <= 10; i++) push(WIDTH'(i));
    chk("ovf_fill", WIDTH'(fill), WIDTH'(DEPTH));
    sweep(1, 1'b0, '0);

    // Ties with back-pressure.
    flush_all();
    push(64'd2); push(64'd7); push(64'd7);
    sweep(5, 1'b0, '0);

    // Flush/start/in_valid together with fill=4, then empty sweep.
    flush_all();
    for (int i = 0; i < 4; i++) push(64'd20 + WIDTH'(i));
    flush_all();
    sweep(0, 1'b0, '0);

    // Start together with an accepted shift.
    push(64'd4);
    sweep(2, 1'b1, 64'd11);

    // Signed/unsigned extremes.
    flush_all();
    push(64'hFFFF_FFFF_FFFF_FFFF); push(64'd1);
    sweep(0, 1'b0, '0);

    // Reset in the second sweep cycle.
    flush_all();
    push(64'd3); push(64'd8); push(64'd6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("mrst_busy", WIDTH'(busy), 0);
    chk("mrst_fill", WIDTH'(fill), 0);
    chk("mrst_in_ready", WIDTH'(in_ready), 0);
    chk("mrst_mem_enable", WIDTH'(mem_enable), 0);
    chk("mrst_valid", WIDTH'(res_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    ref_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_no_result", WIDTH'(res_valid), 0);
      chk("mrst_idle", WIDTH'(busy), 0);
    end

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 5) == 0) flush_all();
      n = $urandom_range(0, 11);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) v = WIDTH'($urandom_range(0, 7));
        else v = {$urandom, $urandom};
        push(v);
      end
      sweep($urandom_range(0, 3), 1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_shift_ctrl.md
# mem_shift_ctrl

Controller for the 8-entry, 64-bit shift data memory in the comparator datapath. Accepts incoming samples with a valid/ready handshake, drives the memory's shift enable and tracks how many entries are valid. On request, it sweeps the valid entries through a read-select port and reports the maximum value and its position through a result handshake.

## Interface
- `WIDTH`, default 64: data width of memory entries and result.
- `DEPTH`, default 8: number of memory entries; must be a power of two ≥ 2.
- `IDXW`, default 3: entry index width, equal to log2(DEPTH).
- `clk`, input, 1: single clock; all state updates on rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: source has a sample on the memory's data input.
- `in_ready`, output, 1: controller will shift the sample this cycle.
- `mem_enable`, output, 1: shift enable to data memory; equals `in_valid & in_ready`.
- `flush`, input, 1: discard all stored entries (fill count to 0).
- `start`, input, 1: request a compare sweep.
- `busy`, output, 1: high in SWEEP and RESULT.
- `mem_sel`, output, IDXW: entry being read; 0 = newest.
- `mem_rdata`, input, WIDTH: combinational read data for `mem_sel`.
- `fill`, output, IDXW+1: number of valid entries, 0..DEPTH.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: consumer accepts result.
- `res_max`, output, WIDTH: largest entry found.
- `res_idx`, output, IDXW: index of `res_max`.
- `res_count`, output, IDXW+1: number of entries compared.

## Operation
- **States:** IDLE, SWEEP, RESULT. Reset enters IDLE.
- **IDLE:**
  - `in_ready = ~flush`.
  - On a handshake, `mem_enable` pulses and `fill` increments, saturating at DEPTH. When full, the oldest entry drops out and `fill` stays at DEPTH.
  - `flush` sets `fill` to 0 next cycle and blocks shifting that cycle. It takes priority over `start`.
  - `start` with `fill > 0` goes to SWEEP.
  - `start` with `fill == 0` goes to RESULT with `res_count=0`, `res_max=0`, `res_idx=0`.
  - `start` together with an accepted shift: the shift happens and the sweep uses the updated fill.
- **SWEEP:**
  - `mem_sel` counts 0..fill-1, one entry per cycle. `in_ready=0`.
  - Running max starts from entry 0. A later entry replaces it only if strictly greater, so ties keep the lower index.
  - The cycle after the compare with `mem_sel = fill-1` enters RESULT. `res_count` is the number of entries compared.
- **RESULT:**
  - `res_valid=1`; `res_max`, `res_idx` and `res_count` are held stable.
  - `res_valid & res_ready` returns to IDLE next cycle.
  - `start`, `flush` and `in_valid` are ignored.
- **Ignored inputs:** `flush` and `start` are ignored outside IDLE; they are not queued.
- **Reset values:**
  - Registered outputs: `fill`, `mem_sel`, `res_*` = 0 and `busy` = 0.
  - `in_ready` and `mem_enable` are forced to 0 while `reset` is high.
- **Reset mid-operation:** reset during SWEEP or RESULT drops to IDLE with `fill=0`. No result is delivered.

## Timing
- `mem_enable` is combinational from `in_valid`, `flush` and state. The memory shifts on the same rising edge that the controller counts.
- Throughput: one sample per cycle in IDLE.
- Sweep latency: `start` sampled at edge t leads to SWEEP over cycles t+1..t+F, where F is the fill count used by the sweep. `res_valid` is high from t+F+1.
- Empty sweep: `res_valid` is high at t+1.
- `mem_rdata` is sampled in the same cycle as its `mem_sel`; no read pipeline.
- Minimum turnaround: the cycle after result acceptance, IDLE accepts samples again.

## Configuration
- `MEM_SHIFT_CTRL_SIGNED_EN`:
  - Defined: the compare treats entries as two's-complement signed, and the initial/empty `res_max` is 0.
  - Undefined (default): the compare is unsigned.
  - Everything else is identical in both builds.

## Test plan
- **Reset mid-sweep:** shift 3 samples, `start`, assert `reset` at the second SWEEP cycle. Required: `busy=0`, `fill=0`, `in_ready=0` while reset is high, and no `res_valid`.
- **Basic sweep:** shift 5, 9, 3 (newest last), then `start`. Required: `mem_sel` reads 0, 1, 2; `res_max=9`, `res_idx=1`, `res_count=3`; `res_valid` exactly 4 cycles after `start`.
- **Overflow:** shift 10 samples 1..10. Required: `fill` saturates at 8; sweep gives `res_max=10`, `res_idx=0`, `res_count=8`.
- **Ties and back-pressure:** entries 7, 7, 2 with newest 7 at index 0, `res_ready` held low 5 cycles. Required: `res_idx=0`; outputs stable while waiting; IDLE one cycle after the handshake.
- **Flush/start priority and empty sweep:**
  - `flush`, `start` and `in_valid` in the same cycle with `fill=4`: `mem_enable=0`, `fill=0`, stays IDLE.
  - `start` with `fill=0`: `res_valid` next cycle with count 0.
- **Signed build:** with `MEM_SHIFT_CTRL_SIGNED_EN` defined, entries 0xFFFF_FFFF_FFFF_FFFF and 1. Required: `res_max=1`. The unsigned build returns the all-ones value.
